// File: rtl/port_ingress_fifo.sv
// Store-and-forward ingress FIFO: packets become visible only once their eop word lands.
// Optional drop statistics counter enabled by defining INGRESS_DROP_STATS_EN.
module port_ingress_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int DEPTH          = 32,
  parameter int PRIORITY_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_vld,
  input  logic                      wr_sop,
  input  logic                      wr_eop,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [PRIORITY_WIDTH-1:0] wr_prio,
  input  logic                      next_data,
  output logic                      ready,
  output logic                      eop,
  output logic [PRIORITY_WIDTH-1:0] priority_out,
  output logic [DATA_WIDTH-1:0]     data_out,
`ifdef INGRESS_DROP_STATS_EN
  output logic [15:0]               drop_cnt,
`endif
  output logic                      wr_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     data;
    logic [PRIORITY_WIDTH-1:0] prio;
    logic                      eop;
  } entry_t;

  typedef enum logic [1:0] {IDLE, RECV, DROP} wr_state_t;

  wr_state_t                 state;
  logic [AW:0]               wr_ptr, commit_ptr, rd_ptr, pkt_cnt;
  logic [PRIORITY_WIDTH-1:0] prio_q;
  entry_t                    mem [DEPTH];
  entry_t                    head, wr_entry;
  logic [AW:0]               mem_addr;
  logic                      mem_we, cmt_full, commit, pop, pop_eop;

  assign wr_full  = (wr_ptr - rd_ptr) == FULL_OCC;
  assign cmt_full = (commit_ptr - rd_ptr) == FULL_OCC;
  assign ready    = pkt_cnt != '0;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign pop      = next_data & ready;
  assign pop_eop  = pop & head.eop;

  assign data_out     = ready ? head.data : '0;
  assign priority_out = ready ? head.prio : '0;
  assign eop          = ready & head.eop;

  assign wr_entry = '{data: wr_data, prio: (wr_sop ? wr_prio : prio_q), eop: wr_eop};

  // A sop inside RECV restarts the packet at commit_ptr, overwriting the orphaned partial.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = wr_ptr;
    case (state)
      IDLE: mem_we = wr_vld & wr_sop & ~wr_full;
      RECV: if (wr_vld) begin
        if (wr_sop) begin
          mem_we   = ~cmt_full;
          mem_addr = commit_ptr;
        end else begin
          mem_we   = ~wr_full;
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  assign commit = mem_we & wr_eop;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      prio_q     <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= mem_addr + ONE;
        if (wr_sop) prio_q <= wr_prio;
        if (wr_eop) commit_ptr <= mem_addr + ONE;
      end else if (state == RECV && wr_vld) begin
        wr_ptr <= commit_ptr;
      end
      case (state)
        IDLE: if (wr_vld && wr_sop && !wr_eop) state <= mem_we ? RECV : DROP;
        RECV: if (wr_vld) begin
          if (wr_eop)      state <= IDLE;
          else if (mem_we) state <= RECV;
          else             state <= DROP;
        end
        DROP: if (wr_vld && wr_eop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + ONE;
      case ({commit, pop_eop})
        2'b10:   pkt_cnt <= pkt_cnt + ONE;
        2'b01:   pkt_cnt <= pkt_cnt - ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

`ifdef INGRESS_DROP_STATS_EN
  logic drop_inc;
  assign drop_inc = (state == IDLE && wr_vld && wr_sop && wr_full) ||
                    (state == RECV && wr_vld && (wr_sop || !mem_we));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             drop_cnt <= '0;
    else if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

// File: doc/port_ingress_fifo.md
PORT_INGRESS_FIFO -- requirements
Module: port_ingress_fifo

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, payload word width; DEPTH, default 32, word entries (power of two, >=4); PRIORITY_WIDTH, default 3, packet priority width.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: wr_vld  input  1  ingress word valid; wr_sop  input  1  first word of packet; wr_eop  input  1  last word of packet.
REQ-005 SHALL have ports: wr_data  input  DATA_WIDTH  ingress word; wr_prio  input  PRIORITY_WIDTH  packet priority, sampled with wr_sop.
REQ-006 SHALL have port: next_data  input  1  pop request from the write arbiter grant bit for this port.
REQ-007 SHALL have ports: ready  output  1  at least one complete packet stored; eop  output  1  head word is last of packet.
REQ-008 SHALL have ports: priority_out  output  PRIORITY_WIDTH  priority of head packet; data_out  output  DATA_WIDTH  head word.
REQ-009 SHALL have port: wr_full  output  1  no free entry (wr_ptr - rd_ptr == DEPTH).

Function
REQ-010 SHALL store per entry {data, prio, eop}; storage is store-and-forward, packet visible to reader only after its eop word is written.
REQ-011 SHALL keep wr_ptr, commit_ptr, rd_ptr of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; occupancy = wr_ptr - rd_ptr.
REQ-012 SHALL run a write FSM with states IDLE, RECV, DROP.
REQ-013 IDLE: wr_vld&wr_sop&!wr_full -> write word, latch prio; if wr_eop commit (stay IDLE) else -> RECV; wr_vld without wr_sop ignored.
REQ-014 RECV: wr_vld&!wr_full -> write word; with wr_eop -> commit_ptr<=wr_ptr+1, pkt_cnt+1, -> IDLE.
REQ-015 RECV: wr_vld&wr_full -> wr_ptr<=commit_ptr (discard partial), -> DROP, or -> IDLE if that word carries wr_eop.
REQ-016 RECV: wr_vld&wr_sop (missing eop) -> wr_ptr rewound to commit_ptr and the sop word written as a new packet start.
REQ-017 DROP: discard all words until wr_vld&wr_eop, then -> IDLE; sop&full in IDLE also -> DROP (or stay IDLE if single-word).
REQ-018 SHALL present head entry first-word-fall-through: data_out/eop/priority_out reflect entry rd_ptr combinationally whenever ready=1, zero otherwise.
REQ-019 Pop occurs when next_data&ready; one word per cycle; rd_ptr+1; popping eop word decrements pkt_cnt.
REQ-020 next_data while ready=0 SHALL be ignored; ready SHALL deassert the cycle after last stored packet's eop pops.
REQ-021 Simultaneous commit and eop-pop SHALL leave pkt_cnt unchanged; pkt_cnt width log2(DEPTH)+1, never wraps.
REQ-022 Packets longer than DEPTH SHALL always be dropped; committed packets SHALL never be corrupted by drops.

Reset
REQ-023 While rst=1: all pointers, pkt_cnt = 0, FSM = IDLE, ready=0, eop=0, data_out=0, priority_out=0, wr_full=0.
REQ-024 rst asserted mid-packet SHALL discard all stored and partial packets; storage array contents need no reset.

Configuration
REQ-025 Macro INGRESS_DROP_STATS_EN defined: extra output drop_cnt (16 bits), +1 per packet entering DROP or rewound by REQ-016, saturating at 16'hFFFF, reset 0.
REQ-026 Macro undefined: no drop_cnt port, no counter logic; all other behaviour identical.

Verification
REQ-027 3-word packet prio=5 (A1,A2,A3) -> ready=1 cycle after A3; priority_out=5, data_out=A1; next_data 3 cycles -> A1,A2,A3 with eop on A3, then ready=0.
REQ-028 DEPTH=32, write 40-word packet -> wr_full at word 33, packet dropped, ready stays 0, drop_cnt=1 when enabled.
REQ-029 Packet P0 committed, then overflowing P1 -> P0 read out intact, P1 absent, occupancy returns to 0.
REQ-030 Pop final eop of P0 same cycle as P1 eop written -> pkt_cnt stays 1, ready stays 1, head = P1 word 0.
REQ-031 sop,word,sop,eop sequence -> first partial discarded, only 2-word second packet read.
REQ-032 rst pulse mid-packet with 2 committed packets -> ready=0 immediately, subsequent packet accepted normally.
